// File: rtl/stg_xtq.sv
// stg_xtq: XT translate stage. Expands macro-ops into µop sequences and
// buffers the µops in a QDEPTH-entry queue, each tagged with its parent PC,
// its position in the sequence and a last flag.
// Optional feature macro: XT_CALLRET_EN (JSR*/BSR*/RET expansion).
// Ports:
//   iw_clk, iw_rst          clock, asynchronous active-high reset
//   iw_valid/ow_ready       macro-instruction input handshake
//   iw_pc, iw_instr         input macro PC and instruction
//   iw_flush                drop the queue and any expansion in progress
//   ow_valid/iw_ready       head µop output handshake
//   ow_pc, ow_instr         parent PC and µop at the queue head
//   ow_uop_idx, ow_uop_last head µop sequence position / last-of-macro flag
// Encoding: opcode in the top 8 bits, AR and SR fields 2 bits, DR fields 4 bits.
module stg_xtq #(
  parameter int unsigned INSTR_W = 24,
  parameter int unsigned PC_W    = 48,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic               iw_valid,
  output logic               ow_ready,
  input  logic [PC_W-1:0]    iw_pc,
  input  logic [INSTR_W-1:0] iw_instr,
  input  logic               iw_flush,
  output logic               ow_valid,
  input  logic               iw_ready,
  output logic [PC_W-1:0]    ow_pc,
  output logic [INSTR_W-1:0] ow_instr,
  output logic [IDX_W-1:0]   ow_uop_idx,
  output logic               ow_uop_last
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Macro opcodes
  localparam logic [7:0] OPC_NOP      = 8'h00;
  localparam logic [7:0] OPC_BTP      = 8'h01;
  localparam logic [7:0] OPC_SETSSP   = 8'h02;
  localparam logic [7:0] OPC_PUSHUR   = 8'h03;
  localparam logic [7:0] OPC_PUSHAUR  = 8'h04;
  localparam logic [7:0] OPC_POPUR    = 8'h05;
  localparam logic [7:0] OPC_POPAUR   = 8'h06;
  // µop opcodes
  localparam logic [7:0] OPC_SUBASI   = 8'h20;
  localparam logic [7:0] OPC_ADDASI   = 8'h21;
  localparam logic [7:0] OPC_STUR     = 8'h22;
  localparam logic [7:0] OPC_STASO    = 8'h23;
  localparam logic [7:0] OPC_LDSO     = 8'h24;
  localparam logic [7:0] OPC_LDASO    = 8'h25;
  localparam logic [7:0] OPC_SRMOVAUR = 8'h26;
  localparam logic [1:0] SR_IDX_SSP   = 2'd1;
`ifdef XT_CALLRET_EN
  localparam logic [7:0] OPC_JSRUR    = 8'h07;
  localparam logic [7:0] OPC_JSRUI    = 8'h08;
  localparam logic [7:0] OPC_BSRSR    = 8'h09;
  localparam logic [7:0] OPC_BSRSO    = 8'h0A;
  localparam logic [7:0] OPC_RET      = 8'h0B;
  localparam logic [7:0] OPC_JCCUR    = 8'h10;
  localparam logic [7:0] OPC_JCCUI    = 8'h11;
  localparam logic [7:0] OPC_BCCSR    = 8'h12;
  localparam logic [7:0] OPC_BALSO    = 8'h14;
  localparam logic [7:0] OPC_SRSUBSI  = 8'h30;
  localparam logic [7:0] OPC_SRSTSO   = 8'h31;
  localparam logic [7:0] OPC_SRMOVUR  = 8'h32;
  localparam logic [7:0] OPC_SRADDSI  = 8'h33;
  localparam logic [7:0] OPC_SRLDSO   = 8'h34;
  localparam logic [7:0] OPC_SRJCCSO  = 8'h35;
  localparam logic [1:0] SR_IDX_LR    = 2'd2;
  localparam logic [1:0] SR_IDX_PC    = 2'd3;
`endif

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  // Number of µops a macro expands into
  function automatic logic [2:0] uop_len(input logic [7:0] opc);
    logic [2:0] n;
    n = 3'd1;
    case (opc)
      OPC_PUSHUR, OPC_PUSHAUR, OPC_POPUR, OPC_POPAUR: n = 3'd2;
`ifdef XT_CALLRET_EN
      OPC_JSRUR, OPC_JSRUI, OPC_BSRSR, OPC_BSRSO:     n = 3'd4;
      OPC_RET:                                        n = 3'd3;
`endif
      default:                                        n = 3'd1;
    endcase
    return n;
  endfunction

  // µop number k of macro mi
  function automatic logic [INSTR_W-1:0] uop_at(input logic [INSTR_W-1:0] mi,
                                                input logic [1:0] k);
    logic [7:0]  opc;
    logic [23:0] u;
    opc = mi[INSTR_W-1 -: 8];
    u   = 24'(mi);
    case (opc)
      OPC_BTP:     u = {OPC_NOP, 16'b0};
      OPC_SETSSP:  u = {OPC_SRMOVAUR, SR_IDX_SSP, mi[15:14], 12'b0};
      OPC_PUSHUR:  u = (k == 2'd0) ? {OPC_SUBASI, mi[15:14], 14'd1}
                                   : {OPC_STUR, mi[15:14], mi[13:10], 10'b0};
      OPC_PUSHAUR: u = (k == 2'd0) ? {OPC_SUBASI, mi[15:14], 14'd2}
                                   : {OPC_STASO, mi[15:14], mi[13:12], 12'd0};
      OPC_POPUR:   u = (k == 2'd0) ? {OPC_ADDASI, mi[11:10], 14'd1}
                                   : {OPC_LDSO, mi[15:12], mi[11:10], 10'h3FF};
      OPC_POPAUR:  u = (k == 2'd0) ? {OPC_ADDASI, mi[13:12], 14'd2}
                                   : {OPC_LDASO, mi[15:14], mi[13:12], 12'hFFE};
`ifdef XT_CALLRET_EN
      OPC_JSRUR, OPC_JSRUI, OPC_BSRSR, OPC_BSRSO: begin
        case (k)
          2'd0:    u = {OPC_SRSUBSI, SR_IDX_SSP, 14'd2};
          2'd1:    u = {OPC_SRSTSO, SR_IDX_SSP, SR_IDX_LR, 12'd0};
          2'd2:    u = {OPC_SRMOVUR, SR_IDX_LR, SR_IDX_PC, 12'b0};
          default: begin
            case (opc)
              OPC_JSRUR: u = {OPC_JCCUR, mi[15:14], 4'b0, 10'b0};
              OPC_JSRUI: u = {OPC_JCCUI, 4'b0, mi[11:0]};
              OPC_BSRSR: u = {OPC_BCCSR, mi[15:12], 4'b0, 8'b0};
              default:   u = {OPC_BALSO, mi[15:0]};
            endcase
          end
        endcase
      end
      OPC_RET: begin
        case (k)
          2'd0:    u = {OPC_SRADDSI, SR_IDX_SSP, 14'd2};
          2'd1:    u = {OPC_SRLDSO, SR_IDX_LR, SR_IDX_SSP, 12'hFFE};
          default: u = {OPC_SRJCCSO, SR_IDX_LR, 4'b0, 10'd1};
        endcase
      end
`endif
      default:     u = 24'(mi);
    endcase
    return INSTR_W'(u);
  endfunction

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   cur_instr;
  logic [PC_W-1:0]      cur_pc;
  logic [IDX_W-1:0]     cur_idx, idx_d;
  logic                 latch;

  logic [INSTR_W-1:0]   q_instr [QDEPTH];
  logic [PC_W-1:0]      q_pc    [QDEPTH];
  logic [IDX_W-1:0]     q_idx   [QDEPTH];
  logic                 q_last  [QDEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 pop, space, push, push_last;
  logic [INSTR_W-1:0]   push_instr;
  logic [PC_W-1:0]      push_pc;
  logic [IDX_W-1:0]     push_idx;
  logic [2:0]           len_in, len_cur;

  assign ow_valid    = (count != '0);
  assign ow_instr    = q_instr[rd_ptr];
  assign ow_pc       = q_pc[rd_ptr];
  assign ow_uop_idx  = q_idx[rd_ptr];
  assign ow_uop_last = q_last[rd_ptr];

  // State register
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, push selection and input ready
  always_comb begin
    state_d    = state_q;
    idx_d      = cur_idx;
    latch      = 1'b0;
    push       = 1'b0;
    push_instr = '0;
    push_pc    = '0;
    push_idx   = '0;
    push_last  = 1'b0;
    len_in     = uop_len(iw_instr[INSTR_W-1 -: 8]);
    len_cur    = uop_len(cur_instr[INSTR_W-1 -: 8]);
    pop        = ow_valid && iw_ready;
    // A full queue that is popped this cycle still has room for one push
    space      = (count < CNT_W'(QDEPTH)) || pop;
    ow_ready   = (state_q == S_IDLE) && space;
    case (state_q)
      S_IDLE: begin
        if (iw_valid && ow_ready && !iw_flush) begin
          push       = 1'b1;
          push_instr = uop_at(iw_instr, 2'd0);
          push_pc    = iw_pc;
          push_last  = (len_in == 3'd1);
          if (len_in != 3'd1) begin
            latch   = 1'b1;
            idx_d   = IDX_W'(1);
            state_d = S_EXPAND;
          end
        end
      end
      S_EXPAND: begin
        if (space && !iw_flush) begin
          push       = 1'b1;
          push_instr = uop_at(cur_instr, 2'(cur_idx));
          push_pc    = cur_pc;
          push_idx   = cur_idx;
          push_last  = ((3'(cur_idx) + 3'd1) == len_cur);
          if (push_last) state_d = S_IDLE;
          else           idx_d   = cur_idx + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (iw_flush) state_d = S_IDLE;
  end

  // Expansion context
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      cur_instr <= '0;
      cur_pc    <= '0;
      cur_idx   <= '0;
    end else begin
      if (latch) begin
        cur_instr <= iw_instr;
        cur_pc    <= iw_pc;
      end
      cur_idx <= idx_d;
    end
  end

  // µop queue
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        q_idx[i]   <= '0;
        q_last[i]  <= 1'b0;
      end
    end else if (iw_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= push_instr;
        q_pc[wr_ptr]    <= push_pc;
        q_idx[wr_ptr]   <= push_idx;
        q_last[wr_ptr]  <= push_last;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
